// File: rtl/alu_instr_sequencer.sv
// Hardwired T0-T6 control sequencer for register-register ALU instructions.
// Optional MUL/DIV path (T6, HI/LO strobes) is enabled by SEQ_MULDIV_EN.
module alu_instr_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int RSEL_W   = 4,
  parameter int OPC_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir_in,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                PCout,
  output logic                Zlowout,
  output logic                ZHighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowIn,
  output logic                ZHighIn,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPC_W-1:0]    alu_op
);

  localparam int RA_HI  = 31 - OPC_W;
  localparam int RB_HI  = RA_HI - RSEL_W;
  localparam int RC_HI  = RB_HI - RSEL_W;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
`ifdef SEQ_MULDIV_EN
    S_T6,
`endif
    S_ERR
  } state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait;
  logic [OPC_W-1:0]    r_opc;
  logic [RSEL_W-1:0]   r_ra;
  logic [RSEL_W-1:0]   r_rb;
  logic [RSEL_W-1:0]   r_rc;
  logic                r_ill;
`ifdef SEQ_MULDIV_EN
  logic                r_md;
`endif

  logic [OPC_W-1:0]    w_opc;
  logic [RSEL_W-1:0]   w_ra;
  logic [RSEL_W-1:0]   w_rb;
  logic [RSEL_W-1:0]   w_rc;
  logic                w_alu;
  logic                w_md;
  logic                w_legal;
  logic                w_unused;

  assign w_opc    = ir_in[31 -: OPC_W];
  assign w_ra     = ir_in[RA_HI -: RSEL_W];
  assign w_rb     = ir_in[RB_HI -: RSEL_W];
  assign w_rc     = ir_in[RC_HI -: RSEL_W];
  assign w_unused = ^ir_in[RC_HI-RSEL_W:0];

  function automatic logic sel_ok(
    input logic [RSEL_W-1:0] s
  );
    logic [31:0] v;
    v = 32'(s);
    return v < 32'(NUM_REGS);
  endfunction

  function automatic logic [NUM_REGS-1:0] oh(
    input logic [RSEL_W-1:0] s
  );
    logic [NUM_REGS-1:0] v;
    for (int i = 0; i < NUM_REGS; i++)
      v[i] = (s == RSEL_W'(i));
    return v;
  endfunction

  always_comb begin
    w_md = 1'b0;
`ifdef SEQ_MULDIV_EN
    w_md = (w_opc == OPC_W'(15)) ||
           (w_opc == OPC_W'(16));
`endif
    w_alu = (w_opc >= OPC_W'(3)) &&
            (w_opc <= OPC_W'(11));
    w_legal = (w_alu || w_md) &&
              sel_ok(w_ra) &&
              sel_ok(w_rb) &&
              sel_ok(w_rc);
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_opc   <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_ill   <= 1'b0;
`ifdef SEQ_MULDIV_EN
      r_md    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_T0;
        end
        S_T0: begin
          r_state <= S_T1;
          r_wait  <= '0;
        end
        S_T1: begin
          // give up after MAX_WAIT cycles without data
          if (mem_ready)
            r_state <= S_T2;
          else if (r_wait == WAIT_W'(MAX_WAIT - 1))
            r_state <= S_ERR;
          else
            r_wait <= r_wait + 1'b1;
        end
        S_T2: begin
          r_state <= S_T3;
          r_opc   <= w_opc;
          r_ra    <= w_ra;
          r_rb    <= w_rb;
          r_rc    <= w_rc;
          r_ill   <= !w_legal;
`ifdef SEQ_MULDIV_EN
          r_md    <= w_md;
`endif
        end
        S_T3: begin
          r_state <= r_ill ? S_IDLE : S_T4;
        end
        S_T4: begin
          r_state <= S_T5;
        end
        S_T5: begin
`ifdef SEQ_MULDIV_EN
          r_state <= r_md ? S_T6 : S_IDLE;
`else
          r_state <= S_IDLE;
`endif
        end
`ifdef SEQ_MULDIV_EN
        S_T6: begin
          r_state <= S_IDLE;
        end
`endif
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = 1'b0;
    error    = 1'b0;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    unique case (r_state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = (r_wait == '0);
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (r_ill) begin
          error = 1'b1;
        end else begin
          Rout = oh(r_rb);
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        Rout   = oh(r_rc);
        alu_op = r_opc;
        ZLowIn = 1'b1;
`ifdef SEQ_MULDIV_EN
        ZHighIn = r_md;
`endif
      end
      S_T5: begin
        Zlowout = 1'b1;
`ifdef SEQ_MULDIV_EN
        if (r_md) begin
          LOin = 1'b1;
        end else begin
          Rin  = oh(r_ra);
          done = 1'b1;
        end
`else
        Rin  = oh(r_ra);
        done = 1'b1;
`endif
      end
`ifdef SEQ_MULDIV_EN
      S_T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
`endif
      S_ERR: begin
        error = 1'b1;
      end
      default: begin
        busy = (r_state != S_IDLE);
      end
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed-vector bench for alu_instr_sequencer.
// MUL/DIV expectations follow SEQ_MULDIV_EN.
module tb_alu_instr_sequencer;

  logic        Clock = 1'b0;
  logic        Clear, start, mem_ready;
  logic [31:0] ir_in;
  logic        busy, done, error;
  logic        PCout, Zlowout, ZHighout, MDRout;
  logic        MARin, PCin, MDRin, IRin, Yin;
  logic        ZLowIn, ZHighIn, HIin, LOin;
  logic        IncPC, Read;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;

  int nrun = 0;
  int nfail = 0;

  always #5 Clock = ~Clock;

  alu_instr_sequencer dut (
    .Clock(Clock), .Clear(Clear), .start(start),
    .mem_ready(mem_ready), .ir_in(ir_in),
    .busy(busy), .done(done), .error(error),
    .PCout(PCout), .Zlowout(Zlowout),
    .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op)
  );

  localparam logic [17:0] BUSY = 18'h1 << 17;
  localparam logic [17:0] DONE = 18'h1 << 16;
  localparam logic [17:0] ERR  = 18'h1 << 15;
  localparam logic [17:0] PCO  = 18'h1 << 14;
  localparam logic [17:0] ZLO  = 18'h1 << 13;
  localparam logic [17:0] ZHO  = 18'h1 << 12;
  localparam logic [17:0] MDRO = 18'h1 << 11;
  localparam logic [17:0] MARI = 18'h1 << 10;
  localparam logic [17:0] PCI  = 18'h1 << 9;
  localparam logic [17:0] MDRI = 18'h1 << 8;
  localparam logic [17:0] IRI  = 18'h1 << 7;
  localparam logic [17:0] YI   = 18'h1 << 6;
  localparam logic [17:0] ZLI  = 18'h1 << 5;
  localparam logic [17:0] ZHI  = 18'h1 << 4;
  localparam logic [17:0] HII  = 18'h1 << 3;
  localparam logic [17:0] LOI  = 18'h1 << 2;
  localparam logic [17:0] INC  = 18'h1 << 1;
  localparam logic [17:0] RD   = 18'h1;

  localparam logic [17:0] C_T0  = BUSY|PCO|MARI|INC|ZLI;
  localparam logic [17:0] C_T1F = BUSY|ZLO|PCI|RD|MDRI;
  localparam logic [17:0] C_T1N = BUSY|ZLO|RD|MDRI;
  localparam logic [17:0] C_T2  = BUSY|MDRO|IRI;

  logic [17:0] ctl;
  logic [54:0] obs;
  assign ctl = {busy, done, error, PCout, Zlowout,
                ZHighout, MDRout, MARin, PCin, MDRin,
                IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
                IncPC, Read};
  assign obs = {ctl, Rin, Rout, alu_op};

  function automatic logic [54:0] ev(
    input logic [17:0] c,
    input logic [15:0] ri,
    input logic [15:0] ro,
    input logic [4:0]  op
  );
    return {c, ri, ro, op};
  endfunction

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic go(input logic [31:0] ir);
    ir_in = ir;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    Clear = 1'b1;
    start = 1'b1;
    tick;
    tick;
    nrun++;
    if (obs !== '0) begin
      nfail++;
      $display("FAIL reset got %h exp 0", obs);
    end
    Clear = 1'b0;
    start = 1'b0;
    tick;
    nrun++;
    if (obs !== '0) begin
      nfail++;
      $display("FAIL reset_idle got %h exp 0", obs);
    end
  endtask

  task automatic test_or;
    logic [54:0] e[$];
    e.push_back(ev(C_T0, 0, 0, 0));
    e.push_back(ev(C_T1F, 0, 0, 0));
    e.push_back(ev(C_T2, 0, 0, 0));
    e.push_back(ev(BUSY|YI, 0, 16'h0004, 0));
    e.push_back(ev(BUSY|ZLI, 0, 16'h0010, 5'b00110));
    e.push_back(ev(BUSY|ZLO|DONE, 16'h0020, 0, 0));
    e.push_back(ev(0, 0, 0, 0));
    go(32'h3292_0000);
    for (int i = 0; i < e.size(); i++) begin
      nrun++;
      if (obs !== e[i]) begin
        nfail++;
        $display("FAIL or[%0d] got %h exp %h", i, obs, e[i]);
      end
      tick;
    end
  endtask

  task automatic test_alu_ops;
    logic [31:0] irs[2];
    logic [15:0] rb[2], rc[2], ra[2];
    logic [4:0]  op[2];
    logic [54:0] e[$];
    irs[0] = 32'h18F8_0000; rb[0] = 16'h8000;
    rc[0] = 16'h0001; ra[0] = 16'h0002; op[0] = 5'd3;
    irs[1] = 32'h5800_0000; rb[1] = 16'h0001;
    rc[1] = 16'h0001; ra[1] = 16'h0001; op[1] = 5'd11;
    for (int k = 0; k < 2; k++) begin
      e.delete();
      e.push_back(ev(C_T0, 0, 0, 0));
      e.push_back(ev(C_T1F, 0, 0, 0));
      e.push_back(ev(C_T2, 0, 0, 0));
      e.push_back(ev(BUSY|YI, 0, rb[k], 0));
      e.push_back(ev(BUSY|ZLI, 0, rc[k], op[k]));
      e.push_back(ev(BUSY|ZLO|DONE, ra[k], 0, 0));
      e.push_back(ev(0, 0, 0, 0));
      go(irs[k]);
      for (int i = 0; i < e.size(); i++) begin
        nrun++;
        if (obs !== e[i]) begin
          nfail++;
          $display("FAIL alu%0d[%0d] got %h exp %h",
                   k, i, obs, e[i]);
        end
        tick;
      end
    end
  endtask

  task automatic test_wait;
    logic [54:0] e[$];
    e.push_back(ev(C_T0, 0, 0, 0));
    e.push_back(ev(C_T1F, 0, 0, 0));
    e.push_back(ev(C_T1N, 0, 0, 0));
    e.push_back(ev(C_T1N, 0, 0, 0));
    e.push_back(ev(C_T1N, 0, 0, 0));
    e.push_back(ev(C_T2, 0, 0, 0));
    e.push_back(ev(BUSY|YI, 0, 16'h0004, 0));
    e.push_back(ev(BUSY|ZLI, 0, 16'h0010, 5'b00110));
    e.push_back(ev(BUSY|ZLO|DONE, 16'h0020, 0, 0));
    e.push_back(ev(0, 0, 0, 0));
    mem_ready = 1'b0;
    go(32'h3292_0000);
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = (i >= 4);
      nrun++;
      if (obs !== e[i]) begin
        nfail++;
        $display("FAIL wait[%0d] got %h exp %h", i, obs, e[i]);
      end
      tick;
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_timeout;
    logic [54:0] e[$];
    e.push_back(ev(C_T0, 0, 0, 0));
    e.push_back(ev(C_T1F, 0, 0, 0));
    for (int j = 0; j < 14; j++)
      e.push_back(ev(C_T1N, 0, 0, 0));
    e.push_back(ev(BUSY|ERR, 0, 0, 0));
    e.push_back(ev(0, 0, 0, 0));
    e.push_back(ev(0, 0, 0, 0));
    mem_ready = 1'b0;
    go(32'h3292_0000);
    for (int i = 0; i < e.size(); i++) begin
      nrun++;
      if (obs !== e[i]) begin
        nfail++;
        $display("FAIL tmo[%0d] got %h exp %h", i, obs, e[i]);
      end
      tick;
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_illegal;
    logic [31:0] irs[$];
    logic [54:0] e[$];
    irs.push_back(32'hF800_0000);
    irs.push_back(32'h6000_0000);
    irs.push_back(32'h1000_0000);
`ifndef SEQ_MULDIV_EN
    irs.push_back(32'h7812_0000);
    irs.push_back(32'h8000_0000);
`endif
    e.push_back(ev(C_T0, 0, 0, 0));
    e.push_back(ev(C_T1F, 0, 0, 0));
    e.push_back(ev(C_T2, 0, 0, 0));
    e.push_back(ev(BUSY|ERR, 0, 0, 0));
    e.push_back(ev(0, 0, 0, 0));
    for (int k = 0; k < irs.size(); k++) begin
      go(irs[k]);
      for (int i = 0; i < e.size(); i++) begin
        nrun++;
        if (obs !== e[i]) begin
          nfail++;
          $display("FAIL ill%0d[%0d] got %h exp %h",
                   k, i, obs, e[i]);
        end
        tick;
      end
    end
  endtask

`ifdef SEQ_MULDIV_EN
  task automatic test_muldiv;
    logic [31:0] irs[2];
    logic [15:0] rb[2], rc[2];
    logic [4:0]  op[2];
    logic [54:0] e[$];
    irs[0] = 32'h7812_0000; rb[0] = 16'h0004;
    rc[0] = 16'h0010; op[0] = 5'b01111;
    irs[1] = 32'h8000_0000; rb[1] = 16'h0001;
    rc[1] = 16'h0001; op[1] = 5'b10000;
    for (int k = 0; k < 2; k++) begin
      e.delete();
      e.push_back(ev(C_T0, 0, 0, 0));
      e.push_back(ev(C_T1F, 0, 0, 0));
      e.push_back(ev(C_T2, 0, 0, 0));
      e.push_back(ev(BUSY|YI, 0, rb[k], 0));
      e.push_back(ev(BUSY|ZLI|ZHI, 0, rc[k], op[k]));
      e.push_back(ev(BUSY|ZLO|LOI, 0, 0, 0));
      e.push_back(ev(BUSY|ZHO|HII|DONE, 0, 0, 0));
      e.push_back(ev(0, 0, 0, 0));
      go(irs[k]);
      for (int i = 0; i < e.size(); i++) begin
        nrun++;
        if (obs !== e[i]) begin
          nfail++;
          $display("FAIL md%0d[%0d] got %h exp %h",
                   k, i, obs, e[i]);
        end
        tick;
      end
    end
  endtask
`endif

  task automatic test_clear;
    logic [54:0] e[$];
    logic [54:0] t4;
    t4 = ev(BUSY|ZLI, 0, 16'h0010, 5'b00110);
    go(32'h3292_0000);
    repeat (4) tick;
    nrun++;
    if (obs !== t4) begin
      nfail++;
      $display("FAIL clr_t4 got %h exp %h", obs, t4);
    end
    Clear = 1'b1;
    start = 1'b1;
    tick;
    Clear = 1'b0;
    start = 1'b0;
    nrun++;
    if (obs !== '0) begin
      nfail++;
      $display("FAIL clr_idle got %h exp 0", obs);
    end
    tick;
    nrun++;
    if (obs !== '0) begin
      nfail++;
      $display("FAIL clr_hold got %h exp 0", obs);
    end
    e.push_back(ev(C_T0, 0, 0, 0));
    e.push_back(ev(C_T1F, 0, 0, 0));
    e.push_back(ev(C_T2, 0, 0, 0));
    e.push_back(ev(BUSY|YI, 0, 16'h0004, 0));
    e.push_back(t4);
    e.push_back(ev(BUSY|ZLO|DONE, 16'h0020, 0, 0));
    e.push_back(ev(0, 0, 0, 0));
    e.push_back(ev(0, 0, 0, 0));
    go(32'h3292_0000);
    for (int i = 0; i < e.size(); i++) begin
      start = (i >= 1 && i <= 3);
      nrun++;
      if (obs !== e[i]) begin
        nfail++;
        $display("FAIL ign[%0d] got %h exp %h", i, obs, e[i]);
      end
      tick;
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [54:0] e[$];
    e.push_back(ev(C_T0, 0, 0, 0));
    e.push_back(ev(C_T1F, 0, 0, 0));
    e.push_back(ev(C_T2, 0, 0, 0));
    e.push_back(ev(BUSY|YI, 0, 16'h0004, 0));
    e.push_back(ev(BUSY|ZLI, 0, 16'h0010, 5'b00110));
    e.push_back(ev(BUSY|ZLO|DONE, 16'h0020, 0, 0));
    e.push_back(ev(0, 0, 0, 0));
    e.push_back(ev(C_T0, 0, 0, 0));
    ir_in = 32'h3292_0000;
    start = 1'b1;
    tick;
    for (int i = 0; i < e.size(); i++) begin
      nrun++;
      if (obs !== e[i]) begin
        nfail++;
        $display("FAIL b2b[%0d] got %h exp %h", i, obs, e[i]);
      end
      tick;
    end
    start = 1'b0;
    Clear = 1'b1;
    tick;
    Clear = 1'b0;
    nrun++;
    if (obs !== '0) begin
      nfail++;
      $display("FAIL b2b_clr got %h exp 0", obs);
    end
  endtask

  initial begin
    Clear = 1'b1;
    start = 1'b0;
    mem_ready = 1'b1;
    ir_in = '0;
    test_reset;
    test_or;
    test_alu_ops;
    test_wait;
    test_timeout;
    test_illegal;
`ifdef SEQ_MULDIV_EN
    test_muldiv;
`endif
    test_clear;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
